result_serializer: RTL

- Sits directly downstream of the matrix multiplier (Calculator) and upstream of uart_tx.
- Snapshots the 144-bit product (9 × 16-bit elements) on a load pulse and streams the active N×N sub-matrix to uart_tx one byte at a time.
- Paces each byte with uart_tx's start/busy handshake.
- Replaces ad-hoc byte indexing in the top level with a proper handshake FSM.

---
 rtl/serializer_pkg.sv | 23 ++
 rtl/result_serializer_elem_index_gen.sv | 67 ++++++
 rtl/result_serializer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// Shared constants and FSM encoding for result_serializer.
// CHECKSUM state exists only when RESULT_SERIALIZER_CHECKSUM_EN is defined.
package serializer_pkg;

    localparam int ELEM_W   = 16;
    localparam int MAX_DIM  = 3;
    localparam int RESULT_W = 144;

    localparam logic [3:0] DIM_MIN = 4'd1;
    localparam logic [3:0] DIM_MAX = 4'(MAX_DIM);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        FINISH
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
        , CHECKSUM
`endif
    } state_e;

endpackage

// File: rtl/result_serializer_elem_index_gen.sv
// Row-major walk over the active N x N sub-matrix: byte_sel, then column, then row.
// last_o flags the final byte of element (dim-1, dim-1).
module elem_index_gen #(
    parameter int BYTES_PER_ELEM = 2,
    parameter int IDX_W          = 2,
    parameter int SEL_W          = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             step_i,
    input  logic [3:0]       dim_i,
    output logic [IDX_W-1:0] r_o,
    output logic [IDX_W-1:0] c_o,
    output logic [SEL_W-1:0] byte_sel_o,
    output logic             last_o
);

    logic [IDX_W-1:0] r_q, r_d, c_q, c_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             sel_wrap, c_wrap, r_end;

    assign sel_wrap = (int'(sel_q) == BYTES_PER_ELEM - 1);
    assign c_wrap   = (int'(c_q) == int'(dim_i) - 1);
    assign r_end    = (int'(r_q) == int'(dim_i) - 1);
    assign last_o   = sel_wrap && c_wrap && r_end;

    always_comb begin
        r_d   = r_q;
        c_d   = c_q;
        sel_d = sel_q;
        if (clear_i) begin
            r_d   = '0;
            c_d   = '0;
            sel_d = '0;
        end else if (step_i) begin
            if (sel_wrap) begin
                sel_d = '0;
                if (c_wrap) begin
                    c_d = '0;
                    r_d = r_q + IDX_W'(1);
                end else begin
                    c_d = c_q + IDX_W'(1);
                end
            end else begin
                sel_d = sel_q + SEL_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q   <= '0;
            c_q   <= '0;
            sel_q <= '0;
        end else begin
            r_q   <= r_d;
            c_q   <= c_d;
            sel_q <= sel_d;
        end
    end

    assign r_o        = r_q;
    assign c_o        = c_q;
    assign byte_sel_o = sel_q;

endmodule

// File: rtl/result_serializer.sv
// Snapshots the multiplier product and streams the N x N sub-matrix to uart_tx, low byte first.
// Optional trailing XOR checksum byte: define RESULT_SERIALIZER_CHECKSUM_EN.
module result_serializer #(
    parameter int ELEM_W  = serializer_pkg::ELEM_W,
    parameter int MAX_DIM = serializer_pkg::MAX_DIM
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load,
    input  logic [ELEM_W*MAX_DIM*MAX_DIM-1:0] result,
    input  logic [3:0]                        dim,
    input  logic                              tx_busy,
    output logic                              tx_start,
    output logic [7:0]                        tx_data,
    output logic                              busy,
    output logic                              done,
    output logic                              dim_err
);

    import serializer_pkg::*;

    localparam int BYTES_PER_ELEM = ELEM_W / 8;
    localparam int NUM_ELEMS      = MAX_DIM * MAX_DIM;
    localparam int RES_BITS       = ELEM_W * NUM_ELEMS;
    localparam int IDX_W          = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;
    localparam int SEL_W          = (BYTES_PER_ELEM > 1) ? $clog2(BYTES_PER_ELEM) : 1;

    state_e               state_q;
    logic [RES_BITS-1:0]  snap_q;
    logic [3:0]           dim_q;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
    logic [7:0]           cks_q;
    logic                 cks_phase_q;
`endif

    logic [IDX_W-1:0]     r, c;
    logic [SEL_W-1:0]     byte_sel;
    logic                 idx_last, idx_clear, idx_step, dim_ok;
    logic [ELEM_W-1:0]    cur_elem;
    logic [7:0]           cur_byte;
    int                   elem_k;

    assign dim_ok    = (dim >= DIM_MIN) && (int'(dim) <= MAX_DIM);
    assign idx_clear = (state_q == IDLE) && load && dim_ok;
    assign idx_step  = (state_q == WAIT_DONE) && !tx_busy && !idx_last;

    elem_index_gen #(
        .BYTES_PER_ELEM (BYTES_PER_ELEM),
        .IDX_W          (IDX_W),
        .SEL_W          (SEL_W)
    ) u_index (
        .clk        (clk),
        .rst        (rst),
        .clear_i    (idx_clear),
        .step_i     (idx_step),
        .dim_i      (dim_q),
        .r_o        (r),
        .c_o        (c),
        .byte_sel_o (byte_sel),
        .last_o     (idx_last)
    );

    // Constant-index muxes keep the selects in range for any r/c encoding.
    always_comb begin
        elem_k   = int'(r) * MAX_DIM + int'(c);
        cur_elem = '0;
        for (int k = 0; k < NUM_ELEMS; k++)
            if (k == elem_k) cur_elem = snap_q[k*ELEM_W +: ELEM_W];
        cur_byte = '0;
        for (int b = 0; b < BYTES_PER_ELEM; b++)
            if (b == int'(byte_sel)) cur_byte = cur_elem[b*8 +: 8];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            snap_q      <= '0;
            dim_q       <= '0;
            tx_start    <= 1'b0;
            tx_data     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            dim_err     <= 1'b0;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
            cks_q       <= '0;
            cks_phase_q <= 1'b0;
`endif
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            dim_err  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        if (dim_ok) begin
                            snap_q  <= result;
                            dim_q   <= dim;
                            busy    <= 1'b1;
                            state_q <= ISSUE;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
                            cks_q       <= '0;
                            cks_phase_q <= 1'b0;
`endif
                        end else begin
                            dim_err <= 1'b1;
                        end
                    end
                end
                // Holds with tx_start low while a previous uart byte is still in flight.
                ISSUE: begin
                    if (!tx_busy) begin
                        tx_start <= 1'b1;
                        tx_data  <= cur_byte;
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
                        cks_q    <= cks_q ^ cur_byte;
`endif
                        state_q  <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (tx_busy) state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
                        if (cks_phase_q)   state_q <= FINISH;
                        else if (idx_last) state_q <= CHECKSUM;
                        else               state_q <= ISSUE;
`else
                        state_q <= idx_last ? FINISH : ISSUE;
`endif
                    end
                end
`ifdef RESULT_SERIALIZER_CHECKSUM_EN
                CHECKSUM: begin
                    if (!tx_busy) begin
                        tx_start    <= 1'b1;
                        tx_data     <= cks_q;
                        cks_phase_q <= 1'b1;
                        state_q     <= WAIT_ACK;
                    end
                end
`endif
                FINISH: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
